// File: rtl/traffic_pkg.sv
// Shared lamp encodings, fault codes and monitor state type for the
// traffic-light safety stage.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_ENC      = 2'b01,
    FLT_CONFLICT = 2'b10,
    FLT_STUCK    = 2'b11
  } fault_code_t;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    NORMAL  = 2'd1,
    FLASH   = 2'd2,
    RECOVER = 2'd3
  } mon_state_t;

  function automatic logic code_valid(input logic [2:0] code);
    return (code == LAMP_GRN) || (code == LAMP_YEL) || (code == LAMP_RED);
  endfunction

endpackage

// File: rtl/lamp_flasher.sv
// Failsafe flash phase generator: phase_on starts high on restart and
// toggles every FLASH_HALF cycles while run is asserted.
module lamp_flasher #(
  parameter int FLASH_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic phase_on
);

  localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt      <= '0;
      phase_on <= 1'b1;
    end else if (run) begin
      if (cnt == CNT_LAST) begin
        cnt      <= '0;
        phase_on <= ~phase_on;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lamp_monitor.sv
// Lamp safety monitor: validates the main/cross light codes, debounces faults
// into a flashing-red failsafe. LAMP_MONITOR_STUCK_EN adds an unchanged-input watchdog.
module lamp_monitor
  import traffic_pkg::*;
#(
  parameter int FAULT_CYCLES   = 3,
  parameter int FLASH_HALF     = 4,
  parameter int RECOVER_CYCLES = 8
`ifdef LAMP_MONITOR_STUCK_EN
  , parameter int STUCK_CYCLES = 64
`endif
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [2:0] iMainSt,
  input  logic [2:0] iCrossSt,
  input  logic       iClearFault,
  output logic [2:0] oMainLamp,
  output logic [2:0] oCrossLamp,
  output logic       oFault,
  output logic [1:0] oFaultCode
);

  localparam int BW = $clog2(FAULT_CYCLES + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [BW-1:0] BAD_LAST = BW'(FAULT_CYCLES - 1);
  localparam logic [RW-1:0] REC_LAST = RW'(RECOVER_CYCLES - 1);

  mon_state_t  state, state_next;
  logic [BW-1:0] bad_cnt;
  logic [RW-1:0] rec_cnt;
  logic [2:0]  main_q, cross_q;
  fault_code_t code_q, cause;
  logic        enc_bad, conflict, bad, stuck_hit, fault_trip;
  logic        phase_on, flash_restart;

  always_comb begin
    enc_bad  = !code_valid(iMainSt) || !code_valid(iCrossSt);
    conflict = !enc_bad && (iMainSt != LAMP_RED) && (iCrossSt != LAMP_RED);
    bad      = enc_bad || conflict;
    if (enc_bad)       cause = FLT_ENC;
    else if (conflict) cause = FLT_CONFLICT;
    else               cause = FLT_STUCK;
  end

`ifdef LAMP_MONITOR_STUCK_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

  logic [5:0]    pair_q;
  logic [SW-1:0] stuck_cnt;
  logic          same_pair;

  assign same_pair = ({iMainSt, iCrossSt} == pair_q);

  always_ff @(posedge iClk) begin
    pair_q <= {iMainSt, iCrossSt};
    if (iRst || (state != NORMAL) || !same_pair) stuck_cnt <= '0;
    else                                          stuck_cnt <= stuck_cnt + 1'b1;
  end

  assign stuck_hit = (state == NORMAL) && same_pair && (stuck_cnt == STUCK_LAST);
`else
  assign stuck_hit = 1'b0;
`endif

  assign fault_trip = (bad && (bad_cnt == BAD_LAST)) || stuck_hit;

  always_ff @(posedge iClk) begin
    if (iRst) state <= STARTUP;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      STARTUP: if (rec_cnt == REC_LAST) state_next = NORMAL;
      NORMAL:  if (fault_trip) state_next = FLASH;
      FLASH:   if (iClearFault && !bad) state_next = RECOVER;
      RECOVER: begin
        if (bad)                       state_next = FLASH;
        else if (rec_cnt == REC_LAST)  state_next = NORMAL;
      end
      default: state_next = STARTUP;
    endcase
  end

  assign flash_restart = (state_next == FLASH) && (state != FLASH);

  // Lamp registers track inputs only in NORMAL; elsewhere they park on red so
  // the first NORMAL cycle (and any hold before a good code) shows red/red.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      bad_cnt <= '0;
      rec_cnt <= '0;
      main_q  <= LAMP_RED;
      cross_q <= LAMP_RED;
      code_q  <= FLT_NONE;
    end else begin
      bad_cnt <= ((state == NORMAL) && bad) ? bad_cnt + 1'b1 : '0;

      if (((state == STARTUP) || ((state == RECOVER) && !bad)) && (rec_cnt != REC_LAST))
        rec_cnt <= rec_cnt + 1'b1;
      else
        rec_cnt <= '0;

      if (state == NORMAL) begin
        if (!bad) begin
          main_q  <= iMainSt;
          cross_q <= iCrossSt;
        end
      end else begin
        main_q  <= LAMP_RED;
        cross_q <= LAMP_RED;
      end

      if (flash_restart)                                   code_q <= cause;
      else if ((state == FLASH) && (state_next == RECOVER)) code_q <= FLT_NONE;
    end
  end

  lamp_flasher #(
    .FLASH_HALF(FLASH_HALF)
  ) u_flasher (
    .clk     (iClk),
    .rst     (iRst),
    .restart (flash_restart),
    .run     (state == FLASH),
    .phase_on(phase_on)
  );

  always_comb begin
    oFault     = (state == FLASH);
    oMainLamp  = main_q;
    oCrossLamp = cross_q;
    if (state == FLASH) begin
      oMainLamp  = phase_on ? LAMP_RED : LAMP_OFF;
      oCrossLamp = phase_on ? LAMP_RED : LAMP_OFF;
    end
  end

  assign oFaultCode = code_q;

endmodule

// File: tb/tb_lamp_monitor.sv
// Self-checking bench for lamp_monitor: directed scenarios followed by random
// input segments, all compared each cycle against a behavioural model.
module tb_lamp_monitor;

  localparam int FAULT_CYCLES   = 3;
  localparam int FLASH_HALF     = 4;
  localparam int RECOVER_CYCLES = 8;
`ifdef LAMP_MONITOR_STUCK_EN
  localparam int STUCK_CYCLES   = 64;
`endif

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  localparam int M_START   = 0;
  localparam int M_RUN     = 1;
  localparam int M_FLASH   = 2;
  localparam int M_RECOVER = 3;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [2:0] iMainSt;
  logic [2:0] iCrossSt;
  logic       iClearFault;
  logic [2:0] oMainLamp;
  logic [2:0] oCrossLamp;
  logic       oFault;
  logic [1:0] oFaultCode;

  lamp_monitor #(
    .FAULT_CYCLES  (FAULT_CYCLES),
    .FLASH_HALF    (FLASH_HALF),
`ifdef LAMP_MONITOR_STUCK_EN
    .STUCK_CYCLES  (STUCK_CYCLES),
`endif
    .RECOVER_CYCLES(RECOVER_CYCLES)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iMainSt    (iMainSt),
    .iCrossSt   (iCrossSt),
    .iClearFault(iClearFault),
    .oMainLamp  (oMainLamp),
    .oCrossLamp (oCrossLamp),
    .oFault     (oFault),
    .oFaultCode (oFaultCode)
  );

  always #5 iClk = ~iClk;

  int tests = 0;
  int fails = 0;

  // Model: mode, consecutive-bad run, recovery count, cycles since flash entry.
  int         m_mode, m_run, m_rec, m_ft;
  logic [2:0] m_main, m_cross;
  logic [1:0] m_code;
`ifdef LAMP_MONITOR_STUCK_EN
  int         m_same;
  logic [5:0] m_prev;
`endif

  function automatic bit ok_code(input logic [2:0] c);
    return (c == RED) || (c == YEL) || (c == GRN);
  endfunction

  task automatic enter_flash(input logic [1:0] why);
    m_mode = M_FLASH;
    m_ft   = 0;
    m_code = why;
  endtask

  task automatic enter_normal();
    m_mode  = M_RUN;
    m_run   = 0;
    m_rec   = 0;
    m_main  = RED;
    m_cross = RED;
`ifdef LAMP_MONITOR_STUCK_EN
    m_same  = 0;
`endif
  endtask

  task automatic model_edge(input logic rst, input logic [2:0] mn, input logic [2:0] cr,
                            input logic clr);
    bit enc, conf, bad, stuck;
    logic [1:0] why;
    enc   = !ok_code(mn) || !ok_code(cr);
    conf  = !enc && (mn != RED) && (cr != RED);
    bad   = enc || conf;
    why   = enc ? 2'd1 : (conf ? 2'd2 : 2'd3);
    stuck = 1'b0;
    if (rst) begin
      m_mode = M_START; m_rec = 0; m_run = 0; m_ft = 0;
      m_code = 2'd0; m_main = RED; m_cross = RED;
`ifdef LAMP_MONITOR_STUCK_EN
      m_same = 0;
`endif
    end else begin
      case (m_mode)
        M_START: begin
          m_rec++;
          if (m_rec == RECOVER_CYCLES) enter_normal();
        end
        M_RUN: begin
`ifdef LAMP_MONITOR_STUCK_EN
          if ({mn, cr} == m_prev) m_same++;
          else m_same = 0;
          stuck = (m_same == STUCK_CYCLES);
`endif
          if (bad) m_run++;
          else begin
            m_run = 0; m_main = mn; m_cross = cr;
          end
          if ((m_run == FAULT_CYCLES) || stuck) enter_flash(why);
        end
        M_FLASH: begin
          m_ft++;
          if (clr && !bad) begin
            m_mode = M_RECOVER; m_rec = 0; m_code = 2'd0;
          end
        end
        default: begin
          if (bad) enter_flash(why);
          else begin
            m_rec++;
            if (m_rec == RECOVER_CYCLES) enter_normal();
          end
        end
      endcase
    end
`ifdef LAMP_MONITOR_STUCK_EN
    m_prev = {mn, cr};
`endif
  endtask

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    logic [2:0] em, ec;
    if (m_mode == M_FLASH) begin
      em = (((m_ft / FLASH_HALF) % 2) == 0) ? RED : OFF;
      ec = em;
    end else if (m_mode == M_RUN) begin
      em = m_main; ec = m_cross;
    end else begin
      em = RED; ec = RED;
    end
    chk($sformatf("%s main_lamp t=%0t", where, $time), oMainLamp, em);
    chk($sformatf("%s cross_lamp t=%0t", where, $time), oCrossLamp, ec);
    chk($sformatf("%s fault t=%0t", where, $time), {2'b00, oFault}, {2'b00, m_mode == M_FLASH});
    chk($sformatf("%s fault_code t=%0t", where, $time), {1'b0, oFaultCode}, {1'b0, m_code});
  endtask

  task automatic step(input logic rst, input logic [2:0] mn, input logic [2:0] cr,
                      input logic clr, input string where);
    iRst = rst; iMainSt = mn; iCrossSt = cr; iClearFault = clr;
    @(posedge iClk);
    model_edge(rst, mn, cr, clr);
    #1;
    check_outputs(where);
  endtask

  task automatic hold(input int n, input logic [2:0] mn, input logic [2:0] cr,
                      input logic clr, input string where);
    repeat (n) step(1'b0, mn, cr, clr, where);
  endtask

  function automatic logic [2:0] rand_code();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 4)      return RED;
    else if (r < 6) return GRN;
    else if (r < 8) return YEL;
    else            return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    step(1'b1, GRN, RED, 1'b0, "reset");
    step(1'b1, GRN, RED, 1'b0, "reset");
    chk("reset main red", oMainLamp, RED);
    chk("reset code none", {1'b0, oFaultCode}, 3'b000);

    hold(12, GRN, RED, 1'b0, "startup_then_follow");
    chk("follow main green", oMainLamp, GRN);

    hold(2, GRN, GRN, 1'b0, "short_conflict");
    hold(3, RED, GRN, 1'b0, "after_glitch");

    hold(3, 3'b011, RED, 1'b0, "enc_fault");
    chk("enc fault code", {1'b0, oFaultCode}, 3'b001);
    hold(15, 3'b011, RED, 1'b0, "flash_pattern");

    step(1'b0, YEL, RED, 1'b1, "clear_good");
    chk("clear drops fault", {2'b00, oFault}, 3'b000);
    hold(12, YEL, RED, 1'b0, "recover_then_follow");

    hold(3, 3'b011, RED, 1'b0, "enc_fault2");
    step(1'b0, OFF, RED, 1'b1, "clear_bad_ignored");
    chk("clear with bad ignored", {2'b00, oFault}, 3'b001);
    hold(2, OFF, RED, 1'b0, "still_flash");
    step(1'b0, GRN, RED, 1'b1, "clear_good2");
    hold(3, RED, RED, 1'b0, "recover_red");
    step(1'b0, GRN, YEL, 1'b0, "recover_conflict");
    chk("recover conflict code", {1'b0, oFaultCode}, 3'b010);
    hold(5, RED, RED, 1'b0, "flash_conflict");
    step(1'b0, RED, RED, 1'b1, "clear_good3");
    hold(10, RED, RED, 1'b0, "recover_to_normal");

`ifdef LAMP_MONITOR_STUCK_EN
    hold(70, GRN, RED, 1'b0, "stuck_watchdog");
    chk("stuck code", {1'b0, oFaultCode}, 3'b011);
`else
    hold(200, GRN, RED, 1'b0, "no_watchdog");
    chk("no stuck fault", {2'b00, oFault}, 3'b000);
`endif

    step(1'b1, RED, RED, 1'b0, "rand_reset");
    for (int seg = 0; seg < 150; seg++) begin
      logic [2:0] mn, cr;
      logic clr, rst;
      int len;
      mn  = rand_code();
      cr  = rand_code();
      clr = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 39) == 0);
      len = int'($urandom_range(1, 4));
      if (rst) step(1'b1, mn, cr, 1'b0, "rand_rst");
      hold(len, mn, cr, clr, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
